vend_payout: RTL and testbench

- Dispense back-end for the coin-operated vend controller.
- Takes one-cycle product/change requests, queues them, and drives the product motor and a single-coin (10tk) change hopper.
- Sequences the hopper with a release-pulse / drop-sensor handshake, with timeout and empty-hopper fault handling.
- Converts the controller's change code (01=10tk, 10=20tk) into individual 10tk coin releases.

---
 rtl/vend_payout.sv | 198 +++++++++++++++++++
 tb/tb_vend_payout.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_payout.sv
// vend_payout: dispense back-end for the coin-operated vend controller.
// Queues product/change requests and sequences the motor and 10tk hopper.

module vend_payout #(
    parameter int PULSE_W = 4,
    parameter int ACK_TO  = 16,
    parameter int DEPTH   = 4
) (
    input  logic       clk,
    input  logic       res,
    input  logic       req,
    input  logic       prod,
    input  logic [1:0] change,
    input  logic       hopper_ack,
    input  logic       hopper_empty,
    input  logic       clr_fault,
    output logic       motor,
    output logic       coin_rel,
    output logic       busy,
    output logic       fault,
    output logic [1:0] owed,
    output logic       ovf,
    output logic [7:0] paid_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0] PW_LAST = 8'(PULSE_W - 1);
    localparam logic [7:0] AT_LAST = 8'(ACK_TO - 1);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE = (AW + 1)'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        PROD  = 3'd2,
        COIN  = 3'd3,
        WAIT  = 3'd4,
        FAULT = 3'd5
    } state_t;

    state_t state;
    state_t state_n;
    state_t coin_go;

    logic [2:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_n;
    logic [2:0]    head;
    logic [1:0]    ncoins;
    logic          full;
    logic          empty;
    logic          want;
    logic          push;
    logic          pop;
    logic          bad;

    logic [7:0] cnt;
    logic [7:0] cnt_n;
    logic       ack_ok;
    logic       motor_n;
    logic       coin_rel_n;
    logic       busy_n;
    logic       fault_n;
    logic       ovf_n;
    logic [1:0] owed_n;
    logic [7:0] paid_n;

    // Request capture: an illegal change code still dispenses the product.
    assign bad    = req && (change == 2'b11);
    assign ncoins = (change == 2'b11) ? 2'b00 : change;
    assign want   = req && (prod || change == 2'b01 || change == 2'b10);
    assign full   = (count == FULL_CNT);
    assign empty  = (count == '0);
    assign push   = want && !full;
    assign pop    = (state == LOAD);
    assign head   = mem[rd_ptr];

    always_comb begin
        count_n = count;
        if (push && !pop)
            count_n = count + ONE;
        else if (pop && !push)
            count_n = count - ONE;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {prod, ncoins};
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_n;
        end
    end

    // Every path into COIN checks the hopper first; an empty hopper faults.
    assign coin_go = hopper_empty ? FAULT : COIN;
    assign ack_ok  = (state == WAIT) && hopper_ack;

    always_ff @(posedge clk or posedge res) begin
        if (res)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (!empty)
                    state_n = LOAD;
            end
            LOAD: begin
                if (head[2])
                    state_n = PROD;
                else if (head[1:0] != 2'b00)
                    state_n = coin_go;
                else
                    state_n = IDLE;
            end
            PROD: begin
                if (cnt == PW_LAST)
                    state_n = (owed != 2'b00) ? coin_go : IDLE;
            end
            COIN: begin
                if (cnt == PW_LAST)
                    state_n = WAIT;
            end
            WAIT: begin
                if (hopper_ack)
                    state_n = (owed == 2'd1) ? IDLE : coin_go;
                else if (cnt == AT_LAST)
                    state_n = FAULT;
            end
            FAULT: begin
                if (clr_fault)
                    state_n = coin_go;
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are computed from the next state and registered.
    always_comb begin
        motor_n    = (state_n == PROD);
        coin_rel_n = (state_n == COIN);
        fault_n    = (state_n == FAULT);
        busy_n     = (count_n != '0) || (state_n != IDLE);
        ovf_n      = ovf || bad || (want && full);
        owed_n     = owed;
        paid_n     = paid_cnt;
        cnt_n      = 8'd0;
        if (state == LOAD)
            owed_n = head[1:0];
        if (ack_ok) begin
            owed_n = owed - 2'd1;
            paid_n = paid_cnt + 8'd1;
        end
        if (state_n == state &&
            (state == PROD || state == COIN || state == WAIT))
            cnt_n = cnt + 8'd1;
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            cnt      <= 8'd0;
            motor    <= 1'b0;
            coin_rel <= 1'b0;
            busy     <= 1'b0;
            fault    <= 1'b0;
            ovf      <= 1'b0;
            owed     <= 2'd0;
            paid_cnt <= 8'd0;
        end else begin
            cnt      <= cnt_n;
            motor    <= motor_n;
            coin_rel <= coin_rel_n;
            busy     <= busy_n;
            fault    <= fault_n;
            ovf      <= ovf_n;
            owed     <= owed_n;
            paid_cnt <= paid_n;
        end
    end

endmodule

// File: tb/tb_vend_payout.sv
// tb_vend_payout: scoreboard bench for vend_payout.
// Stimulus queues expected motor/coin/payment events; a monitor pops them.

module tb_vend_payout;

    localparam int K_MOTOR = 1;
    localparam int K_COIN  = 2;
    localparam int K_PAID  = 3;

    typedef struct {
        int kind;
        int val;
    } ev_t;

    logic       clk = 1'b0;
    logic       res;
    logic       req;
    logic       prod;
    logic [1:0] change;
    logic       ack_m;
    logic       ack_x;
    logic       hopper_empty;
    logic       clr_fault;
    logic       motor;
    logic       coin_rel;
    logic       busy;
    logic       fault;
    logic [1:0] owed;
    logic       ovf;
    logic [7:0] paid_cnt;

    ev_t exp_q[$];
    int  d_chk  = 0;
    int  d_pass = 0;
    int  m_chk  = 0;
    int  m_pass = 0;
    int  ack_dly = 2;
    bit  ack_en  = 1'b1;

    always #5 clk = ~clk;

    vend_payout #(
        .PULSE_W(4),
        .ACK_TO (16),
        .DEPTH  (4)
    ) dut (
        .clk         (clk),
        .res         (res),
        .req         (req),
        .prod        (prod),
        .change      (change),
        .hopper_ack  (ack_m | ack_x),
        .hopper_empty(hopper_empty),
        .clr_fault   (clr_fault),
        .motor       (motor),
        .coin_rel    (coin_rel),
        .busy        (busy),
        .fault       (fault),
        .owed        (owed),
        .ovf         (ovf),
        .paid_cnt    (paid_cnt)
    );

    task automatic chk(input string name, input int act, input int exp);
        d_chk++;
        if (act == exp)
            d_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic expect_ev(input int k, input int v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic take(input int k, input int v);
        ev_t e;
        m_chk++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event: got kind %0d val %0d, expected none", k, v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind == k && e.val == v)
                m_pass++;
            else
                $display("FAIL event: got kind %0d val %0d, expected kind %0d val %0d",
                         k, v, e.kind, e.val);
        end
    endtask

    // Monitor: pulse widths on falling edges, and every paid_cnt change.
    int mw = 0;
    int cw = 0;
    int p_prev = 0;
    always @(negedge clk) begin
        if (res) begin
            mw = 0;
            cw = 0;
            p_prev = 0;
        end else begin
            if (motor) mw++;
            else if (mw != 0) begin
                take(K_MOTOR, mw);
                mw = 0;
            end
            if (coin_rel) cw++;
            else if (cw != 0) begin
                take(K_COIN, cw);
                cw = 0;
            end
            if (int'(paid_cnt) != p_prev) begin
                take(K_PAID, int'(owed) * 256 + int'(paid_cnt));
                p_prev = int'(paid_cnt);
            end
        end
    end

    // Hopper model: one ack pulse ack_dly cycles after each release pulse ends.
    initial begin
        logic prev;
        prev  = 1'b0;
        ack_m = 1'b0;
        forever begin
            @(negedge clk);
            if (prev && !coin_rel && !res && ack_en) begin
                repeat (ack_dly - 1) @(negedge clk);
                ack_m = 1'b1;
                @(negedge clk);
                ack_m = 1'b0;
            end
            prev = coin_rel;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic bit sig(input int sel);
        case (sel)
            0: return motor;
            1: return coin_rel;
            default: return fault;
        endcase
    endfunction

    task automatic wait_lvl(input string name, input int sel, input bit lvl);
        int n = 0;
        while (sig(sel) != lvl && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, (n < 200) ? 1 : 0, 1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk(name, (n < 1000) ? 1 : 0, 1);
    endtask

    task automatic send(input bit p, input logic [1:0] c);
        req    = 1'b1;
        prod   = p;
        change = c;
        @(negedge clk);
        req    = 1'b0;
        prod   = 1'b0;
        change = 2'b00;
    endtask

    task automatic do_reset();
        res = 1'b1;
        repeat (2) @(negedge clk);
        res = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_clr();
        clr_fault = 1'b1;
        @(negedge clk);
        clr_fault = 1'b0;
    endtask

    initial begin
        int lat;
        int n;
        int act;
        res = 1'b1;
        req = 1'b0;
        prod = 1'b0;
        change = 2'b00;
        hopper_empty = 1'b0;
        clr_fault = 1'b0;
        ack_x = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_motor", motor, 0);
        chk("rst_coin_rel", coin_rel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fault", fault, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_owed", owed, 0);
        chk("rst_paid", paid_cnt, 0);
        res = 1'b0;
        @(negedge clk);

        // Product plus two coins.
        expect_ev(K_MOTOR, 4);
        expect_ev(K_COIN, 4);
        expect_ev(K_PAID, 256 + 1);
        expect_ev(K_COIN, 4);
        expect_ev(K_PAID, 2);
        send(1'b1, 2'b10);
        lat = 1;
        while (!motor && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("s1_latency", lat, 3);
        wait_idle("s1_idle");
        chk("s1_paid", paid_cnt, 2);
        chk("s1_owed", owed, 0);
        chk("s1_busy", busy, 0);
        chk("s1_ovf", ovf, 0);

        // Six back-to-back requests: the first is popped on the third
        // cycle, so the sixth finds the four-entry FIFO full.
        for (int k = 0; k < 5; k++) begin
            expect_ev(K_MOTOR, 4);
            expect_ev(K_COIN, 4);
            expect_ev(K_PAID, 3 + k);
        end
        for (int i = 0; i < 6; i++) begin
            req = 1'b1;
            prod = 1'b1;
            change = 2'b01;
            @(negedge clk);
        end
        req = 1'b0;
        prod = 1'b0;
        change = 2'b00;
        chk("s2_ovf", ovf, 1);
        wait_idle("s2_idle");
        chk("s2_paid", paid_cnt, 7);

        // Missing ack -> timeout fault, stray ack ignored, then retry.
        ack_en = 1'b0;
        expect_ev(K_COIN, 4);
        send(1'b0, 2'b01);
        wait_lvl("s3_coin_hi", 1, 1'b1);
        wait_lvl("s3_coin_lo", 1, 1'b0);
        n = 0;
        while (!fault && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("s3_fault_delay", n, 16);
        chk("s3_owed", owed, 1);
        ack_x = 1'b1;
        @(negedge clk);
        ack_x = 1'b0;
        @(negedge clk);
        chk("s3_stray_ack_paid", paid_cnt, 7);
        chk("s3_stray_ack_fault", fault, 1);
        ack_en = 1'b1;
        expect_ev(K_COIN, 4);
        expect_ev(K_PAID, 8);
        pulse_clr();
        chk("s3_fault_clr", fault, 0);
        wait_idle("s3_idle");
        chk("s3_paid", paid_cnt, 8);

        // Empty hopper: fault with no release pulse, then two coins.
        hopper_empty = 1'b1;
        send(1'b0, 2'b10);
        wait_lvl("s4_fault", 2, 1'b1);
        repeat (5) @(negedge clk);
        chk("s4_owed", owed, 2);
        chk("s4_coin_rel", coin_rel, 0);
        chk("s4_fault_hold", fault, 1);
        hopper_empty = 1'b0;
        expect_ev(K_COIN, 4);
        expect_ev(K_PAID, 256 + 9);
        expect_ev(K_COIN, 4);
        expect_ev(K_PAID, 10);
        pulse_clr();
        wait_idle("s4_idle");
        chk("s4_paid", paid_cnt, 10);

        // Illegal change code.
        do_reset();
        chk("s5_ovf_rst", ovf, 0);
        chk("s5_paid_rst", paid_cnt, 0);
        send(1'b0, 2'b11);
        chk("s5_ovf", ovf, 1);
        chk("s5_busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("s5_busy_late", busy, 0);
        expect_ev(K_MOTOR, 4);
        send(1'b1, 2'b11);
        wait_idle("s5_idle");
        chk("s5_paid", paid_cnt, 0);
        chk("s5_owed", owed, 0);

        // Reset during the second cycle of a release pulse, two queued.
        req = 1'b1;
        prod = 1'b0;
        change = 2'b01;
        @(negedge clk);
        prod = 1'b1;
        change = 2'b10;
        @(negedge clk);
        prod = 1'b1;
        change = 2'b00;
        @(negedge clk);
        req = 1'b0;
        prod = 1'b0;
        wait_lvl("s6_coin_hi", 1, 1'b1);
        @(negedge clk);
        chk("s6_coin_mid", coin_rel, 1);
        res = 1'b1;
        #1;
        chk("s6_coin_rel", coin_rel, 0);
        chk("s6_busy", busy, 0);
        chk("s6_motor", motor, 0);
        chk("s6_paid", paid_cnt, 0);
        repeat (2) @(negedge clk);
        res = 1'b0;
        act = 0;
        repeat (40) begin
            @(negedge clk);
            if (motor || coin_rel || busy)
                act++;
        end
        chk("s6_quiet", act, 0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", d_pass + m_pass, d_chk + m_chk);
        $finish;
    end

endmodule
